// File: rtl/gate_barrier_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : gate_barrier_ctrl_pkg
// Purpose  : Shared types and helpers for the gate barrier controller.
// Revision : 1.0 - initial release
// ============================================================================
package gate_barrier_ctrl_pkg;

    // Barrier position/motion state. The encoding is fixed so the state can
    // be read directly on a debug bus.
    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } gate_state_t;

    // Width of the pass counter driven onto the pass_count pins.
    localparam int C_PASS_W = 8;

    // Width of a counter that spans one full lamp period (two half periods).
    function automatic int blink_cnt_width(input int half_ticks);
        return (half_ticks < 1) ? 1 : $clog2(2 * half_ticks);
    endfunction

endpackage : gate_barrier_ctrl_pkg
`default_nettype wire

// File: rtl/gate_barrier_ctrl_sync_edge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : gate_barrier_ctrl_sync_edge
// Purpose  : Two-flop synchroniser for an asynchronous level, plus single-cycle
//            rise and fall pulses derived from the synchronised level.
// Revision : 1.0 - initial release
// ============================================================================
module gate_barrier_ctrl_sync_edge
    import gate_barrier_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Metastability stage, synchronised level and its one-cycle-old copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_prev;
    assign fall  = ~r_sync & r_prev;

endmodule : gate_barrier_ctrl_sync_edge
`default_nettype wire

// File: rtl/gate_barrier_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : gate_barrier_ctrl
// Purpose  : Barrier motor sequencer. Turns the parking FSM's open request and
//            full flag into motor drive, a fully-open flag, a busy flag, a
//            blinking FULL lamp and a count of cars that cleared the beam.
// Revision : 1.0 - initial release
// ============================================================================
module gate_barrier_ctrl
    import gate_barrier_ctrl_pkg::*;
#(
    parameter int TRAVEL_TICKS = 50,
    parameter int HOLD_TICKS   = 200,
    parameter int BLINK_TICKS  = 25,
    parameter int CNT_W        = 16
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                open_req,
    input  logic                full_flag,
    input  logic                car_present,
    output logic                motor_up,
    output logic                motor_down,
    output logic                gate_open,
    output logic                busy,
    output logic                full_lamp,
    output logic [C_PASS_W-1:0] pass_count
);

    localparam logic [CNT_W-1:0] C_TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
    localparam int               C_BLINK_W     = blink_cnt_width(BLINK_TICKS);
    localparam logic [C_BLINK_W-1:0] C_BLINK_LAST = C_BLINK_W'(2 * BLINK_TICKS - 1);
    localparam logic [C_BLINK_W-1:0] C_BLINK_HALF = C_BLINK_W'(BLINK_TICKS);

    gate_state_t          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [C_BLINK_W-1:0] r_blink_cnt;
    logic                 r_open_req_d;

    logic w_open_edge;
    logic w_cnt_zero;
    logic w_car_level;
    logic w_car_rise;
    logic w_car_fall;

    // The beam sensor is asynchronous; everything downstream sees only the
    // synchronised level and its edges.
    gate_barrier_ctrl_sync_edge u_car_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (car_present),
        .level    (w_car_level),
        .rise     (w_car_rise),
        .fall     (w_car_fall)
    );

    // open_req is already synchronous, so a single history flop is enough;
    // a level held high produces exactly one request.
    assign w_open_edge = open_req & ~r_open_req_d;
    assign w_cnt_zero  = (r_cnt == '0);

    // Barrier sequencer: state, shared stroke/hold counter and motor outputs.
    // Outputs decode the state held before this edge, so a transition becomes
    // visible on the pins one cycle after it is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_CLOSED;
            r_cnt        <= '0;
            r_open_req_d <= 1'b0;
            motor_up     <= 1'b0;
            motor_down   <= 1'b0;
            gate_open    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_open_req_d <= open_req;
            motor_up     <= (r_state == ST_OPENING);
            motor_down   <= (r_state == ST_CLOSING);
            gate_open    <= (r_state == ST_OPEN);
            busy         <= (r_state != ST_CLOSED);

            case (r_state)
                ST_CLOSED: begin
                    if (w_open_edge) begin
                        r_state <= ST_OPENING;
                        r_cnt   <= C_TRAVEL_LAST;
                    end
                end
                ST_OPENING: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_OPEN;
                        r_cnt   <= C_HOLD_LAST;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_OPEN: begin
                    // A car in the beam or a fresh request restarts the hold,
                    // so the counter can never expire under a car.
                    if (w_car_level || w_open_edge) begin
                        r_cnt <= C_HOLD_LAST;
                    end else if (w_cnt_zero) begin
                        r_state <= ST_CLOSING;
                        r_cnt   <= C_TRAVEL_LAST;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_CLOSING: begin
                    // Reverse from the current position: the distance back up
                    // equals the distance already travelled down.
                    if (w_car_level || w_open_edge) begin
                        r_state <= ST_OPENING;
                        r_cnt   <= C_TRAVEL_LAST - r_cnt;
                    end else if (w_cnt_zero) begin
                        r_state <= ST_CLOSED;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_CLOSED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Count cars whose synchronised beam signal falls while fully open.
    always_ff @(posedge clk) begin
        if (reset) begin
            pass_count <= '0;
        end else if ((r_state == ST_OPEN) && w_car_fall) begin
            pass_count <= pass_count + C_PASS_W'(1);
        end
    end

    // FULL lamp: high for the first half of each period, restarting from the
    // high phase whenever full_flag is raised again.
    always_ff @(posedge clk) begin
        if (reset || !full_flag) begin
            r_blink_cnt <= '0;
            full_lamp   <= 1'b0;
        end else begin
            full_lamp   <= (r_blink_cnt < C_BLINK_HALF);
            r_blink_cnt <= (r_blink_cnt == C_BLINK_LAST) ? '0 : r_blink_cnt + C_BLINK_W'(1);
        end
    end

    // The motor must never be driven both ways at once.
    a_motor_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(motor_up && motor_down));

    // The synchronised beam cannot rise and fall in the same cycle.
    a_car_edges_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(w_car_rise && w_car_fall));

endmodule : gate_barrier_ctrl
`default_nettype wire

// File: tb/tb_gate_barrier_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_gate_barrier_ctrl
// Purpose  : Directed self-checking bench for gate_barrier_ctrl with short
//            stroke/hold/blink timings.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_barrier_ctrl;

    localparam int TRAVEL_TICKS = 4;
    localparam int HOLD_TICKS   = 6;
    localparam int BLINK_TICKS  = 3;
    localparam int CNT_W        = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       open_req;
    logic       full_flag;
    logic       car_present;
    logic       motor_up;
    logic       motor_down;
    logic       gate_open;
    logic       busy;
    logic       full_lamp;
    logic [7:0] pass_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gate_barrier_ctrl #(
        .TRAVEL_TICKS (TRAVEL_TICKS),
        .HOLD_TICKS   (HOLD_TICKS),
        .BLINK_TICKS  (BLINK_TICKS),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .open_req    (open_req),
        .full_flag   (full_flag),
        .car_present (car_present),
        .motor_up    (motor_up),
        .motor_down  (motor_down),
        .gate_open   (gate_open),
        .busy        (busy),
        .full_lamp   (full_lamp),
        .pass_count  (pass_count)
    );

    // One clock edge; outputs are then sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        open_req    = 1'b0;
        full_flag   = 1'b0;
        car_present = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Reset state, then reset held two cycles in the middle of an opening stroke.
    task automatic test_reset();
        logic [5:0] got;
        do_reset();
        got = {motor_up, motor_down, gate_open, busy, full_lamp, |pass_count};
        n_checks++;
        if (got !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_initial got=%b exp=%b", got, 6'b0);
        end
        open_req = 1'b1;
        step();
        open_req = 1'b0;
        step();
        n_checks++;
        if (motor_up !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_opening motor_up got=%b exp=1", motor_up);
        end
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        got = {motor_up, motor_down, gate_open, busy, full_lamp, |pass_count};
        n_checks++;
        if (got !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid_opening got=%b exp=%b", got, 6'b0);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            got = {motor_up, motor_down, gate_open, busy, full_lamp, |pass_count};
            n_checks++;
            if (got !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_stays_closed k=%0d got=%b exp=%b", k, got, 6'b0);
            end
        end
    endtask

    // Single open request with the beam clear: full open/hold/close cycle.
    task automatic test_basic_cycle();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset();
        open_req = 1'b1;
        for (int n = 0; n <= 16; n++) begin
            step();
            if (n == 0) open_req = 1'b0;
            exp = {(n >= 1 && n <= 4), (n >= 11 && n <= 14), (n >= 5 && n <= 10), (n >= 1 && n <= 14)};
            got = {motor_up, motor_down, gate_open, busy};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL basic_cycle n=%0d up/down/open/busy got=%b exp=%b", n, got, exp);
            end
        end
    endtask

    // Car sits in the beam while open: hold restarts, one pass counted.
    task automatic test_car_hold();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset();
        open_req = 1'b1;
        for (int n = 0; n <= 29; n++) begin
            step();
            if (n == 0)  open_req    = 1'b0;
            if (n == 5)  car_present = 1'b1;
            if (n == 15) car_present = 1'b0;
            exp = {(n >= 1 && n <= 4), (n >= 24 && n <= 27), (n >= 5 && n <= 23), (n >= 1 && n <= 27)};
            got = {motor_up, motor_down, gate_open, busy};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL car_hold n=%0d up/down/open/busy got=%b exp=%b", n, got, exp);
            end
            n_checks++;
            if (pass_count !== ((n >= 18) ? 8'd1 : 8'd0)) begin
                n_fail++;
                $display("FAIL car_hold_pass n=%0d got=%0d exp=%0d", n, pass_count, (n >= 18) ? 1 : 0);
            end
        end
    endtask

    // Car appears while closing: reversal for the mirrored remainder, then a
    // full hold and close. The fall while opening is not counted.
    task automatic test_reversal();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset();
        open_req = 1'b1;
        for (int n = 0; n <= 28; n++) begin
            step();
            if (n == 0)  open_req    = 1'b0;
            if (n == 10) car_present = 1'b1;
            if (n == 11) car_present = 1'b0;
            exp = {((n >= 1 && n <= 4) || (n >= 14 && n <= 16)),
                   ((n >= 11 && n <= 13) || (n >= 23 && n <= 26)),
                   ((n >= 5 && n <= 10) || (n >= 17 && n <= 22)),
                   (n >= 1 && n <= 26)};
            got = {motor_up, motor_down, gate_open, busy};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reversal n=%0d up/down/open/busy got=%b exp=%b", n, got, exp);
            end
        end
        n_checks++;
        if (pass_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reversal_pass got=%0d exp=0", pass_count);
        end
    endtask

    // full_flag high for 12 cycles, low for 2, then high again.
    task automatic test_full_blink();
        logic exp;
        do_reset();
        full_flag = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            step();
            if (j <= 12)      exp = (((j - 1) % 6) < 3);
            else if (j <= 14) exp = 1'b0;
            else              exp = 1'b1;
            n_checks++;
            if (full_lamp !== exp) begin
                n_fail++;
                $display("FAIL full_blink j=%0d got=%b exp=%b", j, full_lamp, exp);
            end
            if (j == 12) full_flag = 1'b0;
            if (j == 14) full_flag = 1'b1;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_blink_busy got=%b exp=0", busy);
        end
        full_flag = 1'b0;
    endtask

    // open_req held for 20 cycles gives exactly one sequence.
    task automatic test_held_open();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset();
        open_req = 1'b1;
        for (int n = 0; n <= 26; n++) begin
            step();
            if (n == 19) open_req = 1'b0;
            exp = {(n >= 1 && n <= 4), (n >= 11 && n <= 14), (n >= 5 && n <= 10), (n >= 1 && n <= 14)};
            got = {motor_up, motor_down, gate_open, busy};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL held_open n=%0d up/down/open/busy got=%b exp=%b", n, got, exp);
            end
        end
    endtask

    // 256 cars pass while the gate is held open: counter wraps to zero.
    task automatic test_pass_wrap();
        do_reset();
        open_req = 1'b1;
        step();
        open_req = 1'b0;
        for (int n = 1; n <= 5; n++) step();
        for (int p = 0; p < 256; p++) begin
            car_present = 1'b1;
            step(); step(); step();
            car_present = 1'b0;
            step(); step(); step();
            if (p == 0 || p == 254 || p == 255) begin
                n_checks++;
                if (pass_count !== 8'((p + 1) % 256)) begin
                    n_fail++;
                    $display("FAIL pass_wrap p=%0d got=%0d exp=%0d", p, pass_count, (p + 1) % 256);
                end
            end
        end
        n_checks++;
        if (gate_open !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_wrap_gate_open got=%b exp=1", gate_open);
        end
    endtask

    initial begin
        reset       = 1'b1;
        open_req    = 1'b0;
        full_flag   = 1'b0;
        car_present = 1'b0;
        test_reset();
        test_basic_cycle();
        test_car_hold();
        test_reversal();
        test_full_blink();
        test_held_open();
        test_pass_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_gate_barrier_ctrl
`default_nettype wire
